// File: rtl/rf_wb_sched.sv
// Write-back scheduler: round-robin arbitration of ALU/load/muldiv onto the register file write port,
// plus a pending-write scoreboard. Optional statistics counters under `RF_WB_SCHED_STATS_EN.
module rf_wb_sched #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req_valid,
  output logic [2:0]          req_ready,
  input  logic [3*ADDR_W-1:0] req_addr,
  input  logic [3*DATA_W-1:0] req_data,
  output logic                rf_wen,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  input  logic                claim_en,
  input  logic [ADDR_W-1:0]   claim_addr,
  output logic                claim_ok,
  output logic [31:0]         busy
`ifdef RF_WB_SCHED_STATS_EN
  ,
  output logic [15:0]         conflict_cnt,
  output logic [7:0]          r0_drop_cnt
`endif
);

  logic [1:0]        last;
  logic [1:0]        sel;
  logic [1:0]        idx;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              release_hit;
  logic [31:0]       busy_next;

  // Rotating-priority search starting one past the last winner; reset gates every grant.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    req_ready = '0;
    sel       = '0;
    idx       = '0;
    xfer      = 1'b0;
    if (rst) begin
      for (int k = 1; k <= 3; k++) begin
        idx = 2'((int'(last) + k) % 3);
        if (!xfer && req_valid[idx]) begin
          req_ready[idx] = 1'b1;
          sel            = idx;
          xfer           = 1'b1;
        end
      end
    end
  end

  assign sel_addr = req_addr[sel*ADDR_W +: ADDR_W];
  assign sel_data = req_data[sel*DATA_W +: DATA_W];

  assign release_hit = rf_wen && (rf_waddr == claim_addr);
  assign claim_ok    = rst && claim_en && (claim_addr != '0) && (!busy[claim_addr] || release_hit);

  // Clear first, then set, so a claim landing on the retiring register keeps its bit.
  always_comb begin
    busy_next = busy;
    if (rf_wen)
      busy_next[rf_waddr] = 1'b0;
    if (claim_ok)
      busy_next[claim_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst) begin
      last     <= 2'd2;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      busy     <= '0;
    end else begin
      rf_wen <= xfer && (sel_addr != '0);
      if (xfer) begin
        last     <= sel;
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
      busy <= busy_next;
    end
  end

`ifdef RF_WB_SCHED_STATS_EN
  logic multi_valid;

  assign multi_valid = (req_valid[0] & req_valid[1]) | (req_valid[0] & req_valid[2]) |
                       (req_valid[1] & req_valid[2]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      conflict_cnt <= '0;
      r0_drop_cnt  <= '0;
    end else begin
      if (multi_valid && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + 16'd1;
      if (xfer && (sel_addr == '0) && (r0_drop_cnt != '1))
        r0_drop_cnt <= r0_drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_sched.sv
// Bench for rf_wb_sched: directed vectors with literal expectations plus a per-cycle reference model.
// Build with RF_WB_SCHED_STATS_EN defined to also cover the statistics counters.
module tb_rf_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        claim_en;
  logic [4:0]  claim_addr;
  logic        claim_ok;
  logic [31:0] busy;
`ifdef RF_WB_SCHED_STATS_EN
  logic [15:0] conflict_cnt;
  logic [7:0]  r0_drop_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;

  rf_wb_sched dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .claim_en(claim_en), .claim_addr(claim_addr), .claim_ok(claim_ok),
    .busy(busy)
`ifdef RF_WB_SCHED_STATS_EN
    , .conflict_cnt(conflict_cnt), .r0_drop_cnt(r0_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state as it will be after the next clock edge.
  bit        model_valid = 1'b0;
  int        m_last = 2;
  bit        m_wen;
  bit [4:0]  m_waddr;
  bit [31:0] m_wdata;
  bit        m_busy [32];
  int        m_conf;
  int        m_r0;

  function automatic int pick(input logic [2:0] v, input int last_idx);
    for (int k = 1; k <= 3; k++)
      if (v[(last_idx + k) % 3]) return (last_idx + k) % 3;
    return -1;
  endfunction

  always @(negedge clk) begin : model
    int        g;
    logic [2:0]  exp_ready;
    logic        exp_ok;
    logic [31:0] busy_vec;
    logic [4:0]  ga;
    logic [31:0] gd;
    g = rst ? pick(req_valid, m_last) : -1;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_ok = rst && claim_en && (claim_addr != 0) &&
             (!m_busy[claim_addr] || (m_wen && m_waddr == claim_addr));
    for (int n = 0; n < 32; n++) busy_vec[n] = m_busy[n];
    if (model_valid) begin
      check("m_ready", 64'(req_ready), 64'(exp_ready));
      check("m_claim_ok", 64'(claim_ok), 64'(exp_ok));
      check("m_wen", 64'(rf_wen), 64'(m_wen));
      check("m_waddr", 64'(rf_waddr), 64'(m_waddr));
      check("m_wdata", 64'(rf_wdata), 64'(m_wdata));
      check("m_busy", 64'(busy), 64'(busy_vec));
`ifdef RF_WB_SCHED_STATS_EN
      check("m_conflict", 64'(conflict_cnt), 64'(m_conf));
      check("m_r0_drop", 64'(r0_drop_cnt), 64'(m_r0));
`endif
    end
    if (!rst) begin
      m_last = 2; m_wen = 0; m_waddr = 0; m_wdata = 0;
      for (int n = 0; n < 32; n++) m_busy[n] = 0;
      m_conf = 0; m_r0 = 0;
      model_valid = 1'b1;
    end else begin
      if (m_wen) m_busy[m_waddr] = 0;
      if (exp_ok) m_busy[claim_addr] = 1;
      if ($countones(req_valid) >= 2 && m_conf < 65535) m_conf++;
      if (g >= 0) begin
        ga = req_addr[g*5 +: 5];
        gd = req_data[g*32 +: 32];
        m_last  = g;
        m_wen   = (ga != 0);
        m_waddr = ga;
        m_wdata = gd;
        if (ga == 0 && m_r0 < 255) m_r0++;
      end else begin
        m_wen = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] grant_seq [6];
    logic [4:0] addr_seq  [6];
    grant_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    addr_seq  = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};

    // Reset with live inputs: grants and claims must be suppressed.
    rst = 1'b0; req_valid = 3'b111; req_addr = '0; req_data = '0;
    claim_en = 1'b1; claim_addr = 5'd3;
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_claim_ok", 64'(claim_ok), 64'h0);
    cyc(); req_valid = '0; claim_en = 1'b0;
    cyc(); rst = 1'b1;
    @(negedge clk);
    check("rst_wen", 64'(rf_wen), 64'h0);
    check("rst_waddr", 64'(rf_waddr), 64'h0);
    check("rst_wdata", 64'(rf_wdata), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);

    // Single ALU write.
    cyc(); req_valid = 3'b001; req_addr[4:0] = 5'd5; req_data[31:0] = 32'h1234_5678;
    @(negedge clk);
    check("alu_ready", 64'(req_ready), 64'h1);
    cyc(); req_valid = '0;
    @(negedge clk);
    check("alu_wen", 64'(rf_wen), 64'h1);
    check("alu_waddr", 64'(rf_waddr), 64'h5);
    check("alu_wdata", 64'(rf_wdata), 64'h1234_5678);

    // Fresh reset, then all three valid: rotation 0,1,2,...
    cyc(); rst = 1'b0;
    cyc(); rst = 1'b1; req_valid = 3'b111;
    req_addr = {5'd3, 5'd2, 5'd1};
    req_data = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      @(negedge clk);
      check("rr_grant", 64'(req_ready), 64'(grant_seq[i]));
      if (i > 0) check("rr_waddr", 64'(rf_waddr), 64'(addr_seq[i-1]));
    end
    cyc(); req_valid = '0;
    @(negedge clk);
    check("rr_last_waddr", 64'(rf_waddr), 64'h3);
    check("rr_last_wdata", 64'(rf_wdata), 64'hCCCC_0003);
`ifdef RF_WB_SCHED_STATS_EN
    check("rr_conflict", 64'(conflict_cnt), 64'd6);
`endif

    // Claim r7, load writes it three cycles later.
    cyc(); claim_en = 1'b1; claim_addr = 5'd7;
    @(negedge clk);
    check("c7_ok", 64'(claim_ok), 64'h1);
    cyc(); claim_en = 1'b0;
    @(negedge clk);
    check("c7_busy_set", 64'(busy[7]), 64'h1);
    cyc();
    cyc(); req_valid = 3'b010; req_addr[9:5] = 5'd7; req_data[63:32] = 32'h0000_7777;
    @(negedge clk);
    check("c7_ready", 64'(req_ready), 64'h2);
    cyc(); req_valid = '0;
    @(negedge clk);
    check("c7_wen", 64'(rf_wen), 64'h1);
    check("c7_busy_hold", 64'(busy[7]), 64'h1);
    cyc();
    @(negedge clk);
    check("c7_busy_clr", 64'(busy[7]), 64'h0);

    // Claim r9 while its write retires: accepted, bit stays set.
    cyc(); claim_en = 1'b1; claim_addr = 5'd9;
    cyc(); claim_en = 1'b0; req_valid = 3'b001; req_addr[4:0] = 5'd9; req_data[31:0] = 32'h99;
    @(negedge clk);
    check("c9_ready", 64'(req_ready), 64'h1);
    cyc(); req_valid = '0; claim_en = 1'b1; claim_addr = 5'd9;
    @(negedge clk);
    check("c9_wen", 64'(rf_wen), 64'h1);
    check("c9_release_ok", 64'(claim_ok), 64'h1);
    cyc();
    @(negedge clk);
    check("c9_busy_ok", 64'(claim_ok), 64'h0);
    check("c9_busy", 64'(busy[9]), 64'h1);
    cyc(); claim_en = 1'b0;

    // Mul/div write to r0: granted but dropped.
    cyc(); req_valid = 3'b100; req_addr[14:10] = 5'd0; req_data[95:64] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("r0_ready", 64'(req_ready), 64'h4);
    cyc(); req_valid = '0;
    @(negedge clk);
    check("r0_wen", 64'(rf_wen), 64'h0);
    check("r0_busy", 64'(busy), 64'h200);
`ifdef RF_WB_SCHED_STATS_EN
    check("r0_drop_cnt", 64'(r0_drop_cnt), 64'h1);
`endif

    // Reset right after a grant to busy r4.
    cyc(); claim_en = 1'b1; claim_addr = 5'd4;
    cyc(); claim_en = 1'b0; req_valid = 3'b001; req_addr[4:0] = 5'd4; req_data[31:0] = 32'h44;
    @(negedge clk);
    check("r4_ready", 64'(req_ready), 64'h1);
    check("r4_busy", 64'(busy), 64'h210);
    cyc(); req_valid = '0; rst = 1'b0;
    @(negedge clk);
    check("r4_wen_pre", 64'(rf_wen), 64'h1);
    cyc(); rst = 1'b1; req_valid = 3'b111; req_addr = {5'd3, 5'd2, 5'd1};
    @(negedge clk);
    check("post_rst_wen", 64'(rf_wen), 64'h0);
    check("post_rst_busy", 64'(busy), 64'h0);
    check("post_rst_grant", 64'(req_ready), 64'h1);
    cyc(); req_valid = '0;
    cyc();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_sched.md
# rf_wb_sched

Write-back scheduler for the 32×32 register file's single synchronous write port. It arbitrates round-robin between three write-back requesters: ALU, load unit and multi-cycle mul/div. It registers the winner onto the file's `wen`/`waddr`/`wdata` inputs. It also keeps a pending-write scoreboard that decode uses to stall on read-after-write hazards.

## Interface
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register address width (32 registers)
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `req_valid`  in  3  per-requester write request; bit 0 ALU, bit 1 load, bit 2 mul/div
- `req_ready`  out  3  per-requester grant, one-hot or zero
- `req_addr`  in  3×ADDR_W  destination register; requester i uses bits [i*5+4:i*5]
- `req_data`  in  3×DATA_W  write data; requester i uses bits [i*32+31:i*32]
- `rf_wen`  out  1  register file write enable (registered)
- `rf_waddr`  out  ADDR_W  register file write address (registered)
- `rf_wdata`  out  DATA_W  register file write data (registered)
- `claim_en`  in  1  decode marks `claim_addr` as pending write
- `claim_addr`  in  ADDR_W  register being claimed
- `claim_ok`  out  1  combinational: claim is accepted this cycle
- `busy`  out  32  scoreboard, bit n = write to rn outstanding; bit 0 always 0

## Operation
- Arbitration, combinational:
  - `req_ready` = one-hot grant to the first asserted `req_valid` bit, searched starting at `(last+1) mod 3`.
  - `last` is a 2-bit register holding the most recently granted index; reset value 2, so requester 0 has first priority.
  - No valid requester → `req_ready`=0 and `last` holds.
- Transfer occurs when `req_valid[i] & req_ready[i]`.
  - `last` ← i.
  - Next cycle: `rf_wen`=1, `rf_waddr`=`req_addr[i]`, `rf_wdata`=`req_data[i]`.
  - Cycles with no transfer: `rf_wen`=0; `rf_waddr`/`rf_wdata` hold their last values.
- Writes to r0:
  - The transfer completes (ready asserted, `last` updated).
  - `rf_wen` stays 0 and no scoreboard change occurs.
- Requesters must hold valid/addr/data stable until granted. A requester whose valid drops without a grant is simply not serviced; no error is raised.
- Scoreboard:
  - `claim_ok` = `claim_en & (claim_addr≠0) & (~busy[claim_addr] | release_hit)`.
  - `release_hit` = `rf_wen & (rf_waddr==claim_addr)`.
  - Claim of r0: `claim_ok`=0, no effect, and decode treats it as no stall.
  - On each clock edge:
    - `busy[rf_waddr]` clears if `rf_wen`.
    - `busy[claim_addr]` sets if `claim_ok`.
    - Set wins over clear for the same address, so the bit stays 1.
- A write-back to a register whose busy bit is 0 is still performed. The scoreboard is unaffected and no error is raised.

## Timing
- Reset (`rst`=0 at edge) forces:
  - `rf_wen`=0, `rf_waddr`=0, `rf_wdata`=0, `busy`=0, `last`=2.
  - During reset `req_ready` is forced to 0 and `claim_ok` to 0.
- Reset mid-operation: an accepted-but-unwritten transfer is discarded, i.e. `rf_wen` is 0 the cycle after reset. All pending busy bits clear.
- Latency: handshake in cycle N → `rf_wen` in cycle N+1 → register file updated at the edge ending N+1 → busy bit cleared at that same edge.
- Throughput: one write per cycle. With all three valid continuously, grants rotate 0,1,2,0,… and each requester is granted exactly every 3rd cycle.
- Read-after-write within the write cycle is not forwarded. Decode must stall while `busy` is set for a source register.

## Configuration
- Macro: `RF_WB_SCHED_STATS_EN`.
- Defined:
  - Adds output `conflict_cnt` (16 bits): saturating count of cycles with two or more `req_valid` bits set.
  - Adds output `r0_drop_cnt` (8 bits): saturating count of completed transfers to r0.
  - Both counters reset to 0 and hold at all-ones when saturated.
- Undefined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- Reset then single ALU request, addr 5, data 0x12345678 → `req_ready`=3'b001 same cycle; next cycle `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0x12345678.
- All three valid for 6 cycles, addrs 1/2/3 → grant sequence 001,010,100,001,010,100; `rf_waddr` sequence 1,2,3,1,2,3 each one cycle later.
- Claim r7, then load writes r7 three cycles later → `busy[7]`=1 from the edge after the claim until the edge ending the `rf_wen` cycle, then 0.
- Claim r9 in the same cycle `rf_wen` writes r9 → `claim_ok`=1 and `busy[9]` remains 1. Claim r9 again while busy with no release → `claim_ok`=0.
- Mul/div request to r0 → `req_ready[2]`=1, `rf_wen` stays 0, `busy` unchanged, `r0_drop_cnt`=1 when the macro is defined.
- `rst`=0 the cycle after a grant to addr 4 with `busy[4]`=1 → next cycle `rf_wen`=0, `busy`=0, next grant with all valid goes to requester 0.
